// File: rtl/stopwatch_counter_if.sv
// Control and display bundle between the stopwatch core and its surroundings.
// The master drives the slow tick and the one-cycle control pulses; the slave
// (the core) returns the BCD time and status flags.
interface stopwatch_counter_if;
    logic        tick_i;
    logic        start_stop_i;
    logic        clear_i;
    logic        lap_i;
    logic [23:0] time_o;
    logic        running_o;
    logic        lap_o;
    logic        wrap_o;

    modport master (
        output tick_i, start_stop_i, clear_i, lap_i,
        input  time_o, running_o, lap_o, wrap_o
    );

    modport slave (
        input  tick_i, start_stop_i, clear_i, lap_i,
        output time_o, running_o, lap_o, wrap_o
    );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD stopwatch core MM:SS.cc. Samples the 100 Hz divider output as data,
// counts one centisecond per rising edge while running, and supports
// start/stop, clear and a lap freeze of the displayed value.
module stopwatch_counter #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    stopwatch_counter_if.slave bus
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

    run_state_t             r_state;
    run_state_t             w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_rise;
    logic                   w_inc;
    logic                   w_rollover;
    logic [5:0][3:0]        r_live;
    logic [5:0][3:0]        w_live_next;
    logic [5:0][3:0]        r_lap_val;
    logic                   r_lap;
    logic                   w_lap_next;
    logic                   r_wrap;

    // Terminal value of each digit; index 0 is cs_ones, index 5 is min_tens.
    function automatic logic [3:0] digit_max(input int unsigned idx);
        case (idx)
            3:       digit_max = 4'd5;
            5:       digit_max = 4'(MAX_MIN_TENS);
            default: digit_max = 4'd9;
        endcase
    endfunction

    // Synchronise the asynchronous tick and keep one history flop for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.tick_i};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Increment uses the run state before any coincident start/stop toggle.
    assign w_inc = w_rise & (r_state == ST_RUNNING) & ~bus.clear_i;

    // Run state and lap flag next-state; clear overrides every other control.
    always_comb begin
        w_state_next = r_state;
        w_lap_next   = r_lap;
        if (bus.clear_i) begin
            w_state_next = ST_STOPPED;
            w_lap_next   = 1'b0;
        end else begin
            if (bus.start_stop_i) begin
                w_state_next = (r_state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
            end
            if (bus.lap_i) begin
                w_lap_next = ~r_lap;
            end
        end
    end

    // Ripple the carry through the six BCD digits; a carry out of min_tens is a rollover.
    always_comb begin : p_incr
        logic carry;
        carry       = w_inc;
        w_live_next = r_live;
        for (int unsigned i = 0; i < 6; i++) begin
            if (carry) begin
                if (r_live[3'(i)] == digit_max(i)) begin
                    w_live_next[3'(i)] = '0;
                end else begin
                    w_live_next[3'(i)] = r_live[3'(i)] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        w_rollover = carry;
        if (bus.clear_i) begin
            w_live_next = '0;
        end
    end

    // Run state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Live digits, lap snapshot (taken pre-increment) and registered wrap pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_live    <= '0;
            r_lap_val <= '0;
            r_lap     <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_live <= w_live_next;
            r_lap  <= w_lap_next;
            r_wrap <= w_rollover;
            if (bus.lap_i && !r_lap && !bus.clear_i) begin
                r_lap_val <= r_live;
            end
        end
    end

    assign bus.time_o    = r_lap ? r_lap_val : r_live;
    assign bus.running_o = (r_state == ST_RUNNING);
    assign bus.lap_o     = r_lap;
    assign bus.wrap_o    = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus random
// control traffic, compared every cycle against a centisecond-count model.
module tb_stopwatch_counter;

    localparam int unsigned WRAP_CS = 360000;   // 60 minutes in centiseconds

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .SYNC_STAGES  (2),
        .MAX_MIN_TENS (5)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (sw_if)
    );

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;
    int unsigned wrap_cnt     = 0;

    // Reference model state: total centiseconds, lap snapshot, flags, and the
    // tick samples taken at the previous three clock edges.
    int unsigned m_n, m_lapv;
    bit          m_run, m_lap, m_wrap;
    bit          s1, s2, s3;
    logic        cur_tick;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int unsigned n);
        int unsigned cs, s, m;
        cs = n % 100;
        s  = (n / 100) % 60;
        m  = n / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_reset();
        m_n = 0; m_lapv = 0; m_run = 0; m_lap = 0; m_wrap = 0;
        s1 = 0; s2 = 0; s3 = 0;
    endtask

    // A tick first sampled high at edge N counts at edge N+2.
    task automatic model_edge(input bit tk, input bit ss, input bit clr, input bit lp);
        bit rise;
        rise = s2 & ~s3;
        s3 = s2; s2 = s1; s1 = tk;
        m_wrap = 0;
        if (clr) begin
            m_n = 0; m_run = 0; m_lap = 0;
        end else begin
            if (lp) begin
                if (!m_lap) begin
                    m_lapv = m_n;
                    m_lap  = 1;
                end else begin
                    m_lap = 0;
                end
            end
            if (rise && m_run) begin
                m_n = (m_n + 1) % WRAP_CS;
                m_wrap = (m_n == 0);
            end
            if (ss) m_run = !m_run;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".time"}, 32'(sw_if.time_o), 32'(to_bcd(m_lap ? m_lapv : m_n)));
        check_eq({tag, ".run"},  32'(sw_if.running_o), 32'(m_run));
        check_eq({tag, ".lap"},  32'(sw_if.lap_o), 32'(m_lap));
        check_eq({tag, ".wrap"}, 32'(sw_if.wrap_o), 32'(m_wrap));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic step(input logic tk, input logic ss, input logic clr, input logic lp);
        cur_tick           = tk;
        sw_if.tick_i       = tk;
        sw_if.start_stop_i = ss;
        sw_if.clear_i      = clr;
        sw_if.lap_i        = lp;
        @(posedge clk_i);
        model_edge(tk, ss, clr, lp);
        @(negedge clk_i);
        if (sw_if.wrap_o === 1'b1) wrap_cnt++;
        check_all("cyc");
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(cur_tick, 0, 0, 0);
    endtask

    task automatic ticks(input int unsigned k, input int unsigned half);
        for (int unsigned t = 0; t < k; t++) begin
            for (int unsigned h = 0; h < half; h++) step(1, 0, 0, 0);
            for (int unsigned h = 0; h < half; h++) step(0, 0, 0, 0);
        end
        idle(2);
    endtask

    task automatic preload(input logic [23:0] bcd, input int unsigned n);
        force u_dut.r_live = bcd;
        #1;
        release u_dut.r_live;
        m_n = n;
    endtask

    initial begin
        sw_if.tick_i = 0; sw_if.start_stop_i = 0; sw_if.clear_i = 0; sw_if.lap_i = 0;
        cur_tick = 0;
        model_reset();

        // Reset state
        #1 rst_i = 1'b1;
        #1;
        check_eq("rst.time", 32'(sw_if.time_o), 32'h0);
        check_eq("rst.run",  32'(sw_if.running_o), 32'h0);
        check_eq("rst.lap",  32'(sw_if.lap_o), 32'h0);
        check_eq("rst.wrap", 32'(sw_if.wrap_o), 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        idle(2);

        // Reset then run: 10 ticks at period 20
        wrap_cnt = 0;
        step(0, 1, 0, 0);
        ticks(10, 10);
        check_eq("run10.time", 32'(sw_if.time_o), 32'h000010);
        check_eq("run10.run",  32'(sw_if.running_o), 32'h1);
        check_eq("run10.nowrap", wrap_cnt, 0);

        // Latency: tick sampled high at edge N counts at edge N+2
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check_eq("lat.N", 32'(sw_if.time_o), 32'h000000);
        step(1, 0, 0, 0);
        check_eq("lat.N1", 32'(sw_if.time_o), 32'h000000);
        step(1, 0, 0, 0);
        check_eq("lat.N2", 32'(sw_if.time_o), 32'h000001);
        idle(50);
        check_eq("lat.hold", 32'(sw_if.time_o), 32'h000001);
        step(0, 0, 0, 0);
        idle(3);

        // Start/stop
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        ticks(5, 2);
        step(0, 1, 0, 0);
        ticks(7, 2);
        check_eq("stop.time", 32'(sw_if.time_o), 32'h000005);
        check_eq("stop.run",  32'(sw_if.running_o), 32'h0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check_eq("ssrise.time", 32'(sw_if.time_o), 32'h000005);
        check_eq("ssrise.run",  32'(sw_if.running_o), 32'h1);
        step(0, 0, 0, 0);
        idle(3);

        // Lap freeze
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        ticks(12, 2);
        step(0, 0, 0, 1);
        ticks(30, 2);
        check_eq("lap.frozen", 32'(sw_if.time_o), 32'h000012);
        check_eq("lap.flag",   32'(sw_if.lap_o), 32'h1);
        step(0, 0, 0, 1);
        check_eq("lap.live", 32'(sw_if.time_o), 32'h000042);
        check_eq("lap.off",  32'(sw_if.lap_o), 32'h0);

        // Carries through centiseconds and seconds
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        ticks(99, 1);
        check_eq("carry.99", 32'(sw_if.time_o), 32'h000099);
        ticks(1, 1);
        check_eq("carry.100", 32'(sw_if.time_o), 32'h000100);
        ticks(5899, 1);
        check_eq("carry.5999", 32'(sw_if.time_o), 32'h005999);
        ticks(1, 1);
        check_eq("carry.10000", 32'(sw_if.time_o), 32'h010000);

        // Rollover from 59:59.99, count preloaded near the end
        preload(24'h595995, 359995);
        idle(2);
        ticks(4, 1);
        check_eq("wrap.max", 32'(sw_if.time_o), 32'h595999);
        wrap_cnt = 0;
        ticks(1, 1);
        check_eq("wrap.time", 32'(sw_if.time_o), 32'h000000);
        check_eq("wrap.pulses", wrap_cnt, 1);
        check_eq("wrap.run", 32'(sw_if.running_o), 32'h1);

        // Clear wins over start/stop and a coincident rise
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        ticks(1234, 1);
        check_eq("clr.pre", 32'(sw_if.time_o), 32'h001234);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        check_eq("clr.time", 32'(sw_if.time_o), 32'h000000);
        check_eq("clr.run",  32'(sw_if.running_o), 32'h0);
        check_eq("clr.lap",  32'(sw_if.lap_o), 32'h0);
        step(0, 0, 0, 0);

        // Random control traffic
        step(0, 1, 0, 0);
        for (int unsigned i = 0; i < 3000; i++) begin
            logic tk;
            tk = ($urandom_range(0, 2) == 0) ? ~cur_tick : cur_tick;
            step(tk, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) == 0);
        end

        // Asynchronous reset mid-count
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        ticks(20, 1);
        step(0, 0, 0, 1);
        ticks(3, 1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("arst.time", 32'(sw_if.time_o), 32'h0);
        check_eq("arst.run",  32'(sw_if.running_o), 32'h0);
        check_eq("arst.lap",  32'(sw_if.lap_o), 32'h0);
        check_eq("arst.wrap", 32'(sw_if.wrap_o), 32'h0);
        model_reset();
        cur_tick = 0;
        sw_if.tick_i = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
